snn_lif_block: RTL and testbench

Parametrised leaky integrate-and-fire neuron block for the SNN datapath: N neurons updated in parallel, one time step per input handshake, for a run of TS time steps. Neuron parameters are sampled once per run from the `neuron_config_t` field set plus a firing threshold. The block emits a per-step spike vector with backpressure and records each neuron's first-spike time, the value read back over AXI4 as neuron data. It is the compute element instantiated T times, once per block, under the Kronecker graph scheduler.

---
 rtl/snn_lif_block.sv | 191 +++++++++++++++++++
 tb/tb_snn_lif_block.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_lif_block.sv
// Parallel leaky integrate-and-fire neuron block: one time step per input handshake, TS steps per run.
// Define SNN_SPIKE_TIME_EN to build the per-neuron first-spike-time registers; otherwise spike_time is tied to TS.
module snn_lif_block #(
    parameter int N   = 2,
    parameter int TS  = 5,
    parameter int VW  = 16,
    parameter int RPW = 4,
    localparam int TW = $clog2(TS + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [VW-1:0]     cfg_v0,
    input  logic [VW-1:0]     cfg_v_rest,
    input  logic [VW-1:0]     cfg_v_leak,
    input  logic [VW-1:0]     cfg_k_syn,
    input  logic [VW-1:0]     cfg_v_th,
    input  logic [RPW-1:0]    cfg_rp,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_spikes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_spikes,
    output logic [TW-1:0]     out_step,
    output logic [N*TW-1:0]   spike_time
);

    localparam logic [TW-1:0] TS_VAL    = TW'(TS);
    localparam logic [TW-1:0] LAST_STEP = TW'(TS - 1);
    localparam logic signed [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};
    localparam logic signed [VW-1:0] V_MIN = {1'b1, {(VW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_IN, S_UPDATE, S_EMIT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [VW-1:0] v0_q, rest_q, leak_q, ksyn_q, th_q;
    logic [RPW-1:0]       rpcfg_q;

    logic [TW-1:0]        step_q;
    logic [N-1:0]         in_q;
    logic signed [VW-1:0] v_q   [N];
    logic [RPW-1:0]       rp_q  [N];

    logic signed [VW+1:0] ksyn_x, leak_x;
    logic signed [VW+1:0] sum   [N];
    logic signed [VW-1:0] sat   [N];
    logic signed [VW-1:0] flr   [N];
    logic signed [VW-1:0] v_nxt [N];
    logic [RPW-1:0]       rp_nxt[N];
    logic [N-1:0]         fire;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_INIT;
            end
            S_INIT:    state_d = S_WAIT_IN;
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_UPDATE;
            end
            S_UPDATE:  state_d = S_EMIT;
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = (step_q == LAST_STEP) ? S_DONE : S_WAIT_IN;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ksyn_x = $signed({{2{ksyn_q[VW-1]}}, ksyn_q});
    assign leak_x = $signed({{2{leak_q[VW-1]}}, leak_q});

    // Two guard bits keep V + K - LEAK exact before clamping back to VW bits.
    always_comb begin
        fire = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v_nxt[i]  = v_q[i];
            rp_nxt[i] = rp_q[i];
            if (in_q[i]) sum[i] = $signed({{2{v_q[i][VW-1]}}, v_q[i]}) + ksyn_x - leak_x;
            else         sum[i] = $signed({{2{v_q[i][VW-1]}}, v_q[i]}) - leak_x;
            if ((sum[i][VW+1:VW-1] == 3'b000) || (sum[i][VW+1:VW-1] == 3'b111))
                sat[i] = sum[i][VW-1:0];
            else
                sat[i] = sum[i][VW+1] ? V_MIN : V_MAX;
            flr[i] = (sat[i] < rest_q) ? rest_q : sat[i];
            if (rp_q[i] != '0) begin
                rp_nxt[i] = rp_q[i] - RPW'(1);
                v_nxt[i]  = rest_q;
            end else if (flr[i] >= th_q) begin
                fire[i]   = 1'b1;
                v_nxt[i]  = rest_q;
                rp_nxt[i] = rpcfg_q;
            end else begin
                v_nxt[i]  = flr[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v0_q       <= '0;
            rest_q     <= '0;
            leak_q     <= '0;
            ksyn_q     <= '0;
            th_q       <= '0;
            rpcfg_q    <= '0;
            step_q     <= '0;
            in_q       <= '0;
            out_spikes <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                v_q[i]  <= '0;
                rp_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    v0_q    <= cfg_v0;
                    rest_q  <= cfg_v_rest;
                    leak_q  <= cfg_v_leak;
                    ksyn_q  <= cfg_k_syn;
                    th_q    <= cfg_v_th;
                    rpcfg_q <= cfg_rp;
                end
                S_INIT: begin
                    step_q <= '0;
                    for (int unsigned i = 0; i < N; i++) begin
                        v_q[i]  <= v0_q;
                        rp_q[i] <= '0;
                    end
                end
                S_WAIT_IN: if (in_valid) in_q <= in_spikes;
                S_UPDATE: begin
                    out_spikes <= fire;
                    for (int unsigned i = 0; i < N; i++) begin
                        v_q[i]  <= v_nxt[i];
                        rp_q[i] <= rp_nxt[i];
                    end
                end
                S_EMIT: if (out_ready && (step_q != LAST_STEP)) step_q <= step_q + TW'(1);
                default: ;
            endcase
        end
    end

    assign out_step = step_q;

`ifdef SNN_SPIKE_TIME_EN
    logic [TW-1:0] st_q [N];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < N; i++) st_q[i] <= TS_VAL;
        end else if (state_q == S_INIT) begin
            for (int unsigned i = 0; i < N; i++) st_q[i] <= TS_VAL;
        end else if (state_q == S_UPDATE) begin
            for (int unsigned i = 0; i < N; i++)
                if (fire[i] && (st_q[i] == TS_VAL)) st_q[i] <= step_q;
        end
    end

    always_comb begin
        spike_time = '0;
        for (int unsigned i = 0; i < N; i++) spike_time[i*TW +: TW] = st_q[i];
    end
`else
    assign spike_time = {N{TS_VAL}};
`endif

endmodule

// File: tb/tb_snn_lif_block.sv
// Scoreboarded bench for snn_lif_block: a driver pushes model predictions per step, a monitor pops on output handshakes.
module tb_snn_lif_block;

    localparam int N   = 2;
    localparam int TS  = 5;
    localparam int VW  = 16;
    localparam int RPW = 4;
    localparam int TW  = $clog2(TS + 1);
    localparam int VMAX = (1 << (VW - 1)) - 1;
    localparam int VMIN = -(1 << (VW - 1));

`ifdef SNN_SPIKE_TIME_EN
    localparam logic [N*TW-1:0] ST_BASIC = {3'd5, 3'd1};
`else
    localparam logic [N*TW-1:0] ST_BASIC = {3'd5, 3'd5};
`endif
    localparam logic [N*TW-1:0] ST_NONE = {3'd5, 3'd5};

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [VW-1:0]     cfg_v0, cfg_v_rest, cfg_v_leak, cfg_k_syn, cfg_v_th;
    logic [RPW-1:0]    cfg_rp;
    logic              start, busy, done;
    logic              in_valid, in_ready;
    logic [N-1:0]      in_spikes;
    logic              out_valid, out_ready;
    logic [N-1:0]      out_spikes;
    logic [TW-1:0]     out_step;
    logic [N*TW-1:0]   spike_time;

    snn_lif_block #(.N(N), .TS(TS), .VW(VW), .RPW(RPW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_v0(cfg_v0), .cfg_v_rest(cfg_v_rest), .cfg_v_leak(cfg_v_leak),
        .cfg_k_syn(cfg_k_syn), .cfg_v_th(cfg_v_th), .cfg_rp(cfg_rp),
        .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
        .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
        .out_step(out_step), .spike_time(spike_time)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [N-1:0]  spk;
        logic [TW-1:0] step;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    // bench-side configuration and reference model state
    int c_v0, c_rest, c_leak, c_k, c_th, c_rp;
    int m_v0, m_rest, m_leak, m_k, m_th, m_rp;
    int m_vm [N];
    int m_rc [N];
    int m_st [N];

    logic [N-1:0] stim [TS];
    int           dly  [TS];
    logic [N-1:0] obs  [TS];
    logic [N-1:0] basic_obs [TS];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic apply_cfg();
        cfg_v0     = VW'(c_v0);
        cfg_v_rest = VW'(c_rest);
        cfg_v_leak = VW'(c_leak);
        cfg_k_syn  = VW'(c_k);
        cfg_v_th   = VW'(c_th);
        cfg_rp     = RPW'(c_rp);
    endtask

    task automatic base_cfg();
        c_v0 = 0; c_rest = 0; c_leak = 1; c_k = 4; c_th = 6; c_rp = 1;
        apply_cfg();
    endtask

    task automatic model_start();
        m_v0 = c_v0; m_rest = c_rest; m_leak = c_leak; m_k = c_k; m_th = c_th; m_rp = c_rp;
        for (int i = 0; i < N; i++) begin
            m_vm[i] = m_v0;
            m_rc[i] = 0;
            m_st[i] = TS;
        end
    endtask

    task automatic model_step(input logic [N-1:0] ins, input int t, output logic [N-1:0] spk);
        int s;
        spk = '0;
        for (int i = 0; i < N; i++) begin
            if (m_rc[i] > 0) begin
                m_rc[i]--;
                m_vm[i] = m_rest;
            end else begin
                s = m_vm[i] + (ins[i] ? m_k : 0) - m_leak;
                if (s > VMAX) s = VMAX;
                if (s < VMIN) s = VMIN;
                if (s < m_rest) s = m_rest;
                if (s >= m_th) begin
                    spk[i]  = 1'b1;
                    m_vm[i] = m_rest;
                    m_rc[i] = m_rp;
                    if (m_st[i] == TS) m_st[i] = t;
                end else begin
                    m_vm[i] = s;
                end
            end
        end
    endtask

    function automatic logic [N*TW-1:0] model_st();
        logic [N*TW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
`ifdef SNN_SPIKE_TIME_EN
            r[i*TW +: TW] = TW'(m_st[i]);
`else
            r[i*TW +: TW] = TW'(TS);
`endif
        end
        return r;
    endfunction

    always @(negedge aclk) begin
        if (done) done_cnt++;
        if (aresetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h expected=none at %0t", out_spikes, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_spikes", 64'(out_spikes), 64'(e.spk));
                chk("out_step", 64'(out_step), 64'(e.step));
                if (int'(out_step) < TS) obs[out_step] = out_spikes;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_spikes"}, 64'(out_spikes), 64'(0));
        chk({tag, "_out_step"}, 64'(out_step), 64'(0));
        chk({tag, "_spike_time"}, 64'(spike_time), 64'(ST_NONE));
    endtask

    task automatic do_run(input int stall_step, input int stall_len, input int abort_step, input bit poke);
        int w, d, done_before;
        logic [N-1:0] spk;
        exp_t e;
        done_before = done_cnt;
        for (int t = 0; t < TS; t++) obs[t] = '1;
        @(posedge aclk); #1;
        start = 1'b1;
        model_start();
        @(posedge aclk); #1;
        start = 1'b0;
        chk("init_busy", 64'(busy), 64'(1));
        chk("init_in_ready", 64'(in_ready), 64'(0));
        for (int t = 0; t < TS; t++) begin
            w = 0;
            while (!in_ready && w < 20) begin
                @(posedge aclk); #1;
                w++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 64'(0), 64'(1));
                return;
            end
            if (t == 0) chk("start_latency", 64'(w), 64'(1));
            if (poke && t == 1) begin
                start = 1'b1;
                cfg_k_syn = VW'(999);
                cfg_v_th  = VW'(1);
            end
            if (poke && t == 3) start = 1'b0;
            in_spikes = stim[t];
            in_valid  = 1'b1;
            model_step(stim[t], t, spk);
            e.spk = spk;
            e.step = TW'(t);
            exp_q.push_back(e);
            @(posedge aclk); #1;
            in_valid  = 1'b0;
            in_spikes = N'($urandom);
            chk("in_ready_after_hs", 64'(in_ready), 64'(0));
            if (t == abort_step) begin
                aresetn = 1'b0;
                #1;
                check_reset_values("midrun_reset");
                void'(exp_q.pop_back());
                @(posedge aclk); #1;
                aresetn = 1'b1;
                chk("no_done_on_reset", 64'(done_cnt - done_before), 64'(0));
                apply_cfg();
                return;
            end
            @(posedge aclk); #1;
            d = (t == stall_step) ? stall_len : dly[t];
            for (int k = 0; k < d; k++) begin
                chk("stall_out_valid", 64'(out_valid), 64'(1));
                chk("stall_in_ready", 64'(in_ready), 64'(0));
                chk("stall_out_step", 64'(out_step), 64'(t));
                chk("stall_out_spikes", 64'(out_spikes), 64'(spk));
                @(posedge aclk); #1;
            end
            out_ready = 1'b1;
            @(posedge aclk); #1;
            out_ready = 1'b0;
        end
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'(1));
        @(posedge aclk); #1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        chk("done_count", 64'(done_cnt - done_before), 64'(1));
        chk("spike_time", 64'(spike_time), 64'(model_st()));
        apply_cfg();
    endtask

    task automatic clear_delays();
        for (int t = 0; t < TS; t++) dly[t] = 0;
    endtask

    initial begin
        aresetn = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_spikes = '0;
        out_ready = 1'b0;
        base_cfg();
        clear_delays();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_values("reset");
        aresetn = 1'b1;

        // basic firing
        for (int t = 0; t < TS; t++) stim[t] = 2'b01;
        do_run(-1, 0, -1, 1'b0);
        for (int t = 0; t < TS; t++) basic_obs[t] = obs[t];
        chk("basic_spikes_n0", 64'({obs[4][0], obs[3][0], obs[2][0], obs[1][0], obs[0][0]}), 64'(5'b10010));
        chk("basic_spikes_n1", 64'({obs[4][1], obs[3][1], obs[2][1], obs[1][1], obs[0][1]}), 64'(0));
        chk("basic_spike_time", 64'(spike_time), 64'(ST_BASIC));

        // leak floor
        c_v0 = 5;
        apply_cfg();
        for (int t = 0; t < TS; t++) stim[t] = 2'b00;
        do_run(-1, 0, -1, 1'b0);
        for (int t = 0; t < TS; t++) chk("leak_no_spike", 64'(obs[t]), 64'(0));
        chk("leak_spike_time", 64'(spike_time), 64'(ST_NONE));

        // saturation
        c_v0 = VMAX; c_k = VMAX; c_th = VMAX; c_leak = 0;
        apply_cfg();
        stim[0] = 2'b10;
        for (int t = 1; t < TS; t++) stim[t] = N'($urandom);
        do_run(-1, 0, -1, 1'b0);
        chk("sat_step0", 64'(obs[0]), 64'(2'b11));

        // backpressure
        base_cfg();
        for (int t = 0; t < TS; t++) stim[t] = 2'b01;
        do_run(2, 10, -1, 1'b0);
        for (int t = 0; t < TS; t++) chk("stall_matches_basic", 64'(obs[t]), 64'(basic_obs[t]));
        chk("stall_spike_time", 64'(spike_time), 64'(ST_BASIC));

        // reset mid-run, then rerun
        do_run(-1, 0, 3, 1'b0);
        do_run(-1, 0, -1, 1'b0);
        for (int t = 0; t < TS; t++) chk("rerun_matches_basic", 64'(obs[t]), 64'(basic_obs[t]));
        chk("rerun_spike_time", 64'(spike_time), 64'(ST_BASIC));

        // start and cfg changes during a run
        do_run(-1, 0, -1, 1'b1);
        for (int t = 0; t < TS; t++) chk("poke_matches_basic", 64'(obs[t]), 64'(basic_obs[t]));

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            c_v0   = int'($urandom_range(0, 40)) - 20;
            c_rest = int'($urandom_range(0, 10)) - 5;
            c_leak = int'($urandom_range(0, 3));
            c_k    = int'($urandom_range(0, 10));
            c_th   = c_rest + int'($urandom_range(1, 15));
            c_rp   = int'($urandom_range(0, 3));
            apply_cfg();
            for (int t = 0; t < TS; t++) begin
                stim[t] = N'($urandom);
                dly[t]  = int'($urandom_range(0, 3));
            end
            do_run(-1, 0, -1, 1'b0);
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
